// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with binary pointers, an occupancy count,
// almost-full/almost-empty thresholds, a synchronous flush, sticky
// overflow/underflow flags and a selectable read mode (registered or FWFT).
module sync_fifo #(
    parameter int Width       = 12,
    parameter int Depth       = 4,
    parameter int AlmostFull  = 3,
    parameter int AlmostEmpty = 1,
    parameter int FWFT        = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     w,
    input  logic [Width-1:0]         wd,
    output logic                     wfull,
    output logic                     walmostfull,
    input  logic                     r,
    output logic [Width-1:0]         rd,
    output logic                     rempty,
    output logic                     ralmostempty,
    output logic [$clog2(Depth):0]   level,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     errclr
);

    localparam int PW = $clog2(Depth);
    localparam int LW = PW + 1;

    // Elaboration-time checks on parameter legality
    if (Width < 1) begin : g_bad_width
        $error("sync_fifo: Width must be >= 1");
    end
    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: Depth must be a power of 2 and >= 2");
    end
    if (AlmostFull < 1 || AlmostFull > Depth) begin : g_bad_af
        $error("sync_fifo: AlmostFull must be in 1..Depth");
    end
    if (AlmostEmpty < 0 || AlmostEmpty > Depth - 1) begin : g_bad_ae
        $error("sync_fifo: AlmostEmpty must be in 0..Depth-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("sync_fifo: FWFT must be 0 or 1");
    end

    logic [Width-1:0] mem_q [Depth];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_acc, rd_acc;

    // Flags come straight from the registered level, so they move on the same
    // edge as the level itself.
    assign rempty       = (level_q == '0);
    assign wfull        = (level_q == LW'(Depth));
    assign walmostfull  = (level_q >= LW'(AlmostFull));
    assign ralmostempty = (level_q <= LW'(AlmostEmpty));
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Flush blocks both sides; a full/empty FIFO rejects the matching request.
    assign wr_acc = w & ~wfull  & ~flush;
    assign rd_acc = r & ~rempty & ~flush;

    // Next-state for pointers, occupancy and the sticky error flags
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + PW'(1);
            if (rd_acc) rptr_d = rptr_q + PW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end

        // Clear first so a same-cycle set takes precedence
        if (errclr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (w & wfull & ~flush)  overflow_d  = 1'b1;
        if (r & rempty & ~flush) underflow_d = 1'b1;
    end

    // Control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wptr_q] <= wd;
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is presented combinationally; only meaningful when not empty
        assign rd = mem_q[rptr_q];
    end else begin : g_reg
        logic [Width-1:0] rd_q, rd_d;

        // Capture the head word on an accepted pop, hold otherwise (incl. flush)
        always_comb begin
            rd_d = rd_q;
            if (rd_acc) rd_d = mem_q[rptr_q];
        end

        // Registered read data
        always_ff @(posedge clk or posedge rst) begin
            if (rst) rd_q <= '0;
            else     rd_q <= rd_d;
        end

        assign rd = rd_q;
    end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed test of sync_fifo. Two instances (registered and
// FWFT read) share all inputs so flag/level behaviour and both read paths
// are checked against the same hand-computed sequence.
module tb_sync_fifo;

    logic        clk, rst, flush, w, r, errclr;
    logic [11:0] wd;

    logic        wfull_a, walmostfull_a, rempty_a, ralmostempty_a, overflow_a, underflow_a;
    logic [11:0] rd_a;
    logic [2:0]  level_a;
    logic        wfull_b, walmostfull_b, rempty_b, ralmostempty_b, overflow_b, underflow_b;
    logic [11:0] rd_b;
    logic [2:0]  level_b;

    int n_chk  = 0;
    int n_fail = 0;

    sync_fifo #(.Width(12), .Depth(4), .AlmostFull(3), .AlmostEmpty(1), .FWFT(0)) u_reg (
        .clk(clk), .rst(rst), .flush(flush), .w(w), .wd(wd),
        .wfull(wfull_a), .walmostfull(walmostfull_a), .r(r), .rd(rd_a),
        .rempty(rempty_a), .ralmostempty(ralmostempty_a), .level(level_a),
        .overflow(overflow_a), .underflow(underflow_a), .errclr(errclr)
    );

    sync_fifo #(.Width(12), .Depth(4), .AlmostFull(3), .AlmostEmpty(1), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .w(w), .wd(wd),
        .wfull(wfull_b), .walmostfull(walmostfull_b), .r(r), .rd(rd_b),
        .rempty(rempty_b), .ralmostempty(ralmostempty_b), .level(level_b),
        .overflow(overflow_b), .underflow(underflow_b), .errclr(errclr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Advance one edge and settle 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] d);
        w = 1'b1; wd = d;
        tick();
        w = 1'b0;
    endtask

    task automatic pop();
        r = 1'b1;
        tick();
        r = 1'b0;
    endtask

    // Both instances must agree on all non-data state
    task automatic chk_state(input string tag, input logic [2:0] lvl, input logic emp,
                             input logic ful, input logic ovf, input logic unf);
        chk({tag, ".level"},     32'(level_a),   32'(lvl));
        chk({tag, ".level_f"},   32'(level_b),   32'(lvl));
        chk({tag, ".rempty"},    32'(rempty_a),  32'(emp));
        chk({tag, ".wfull"},     32'(wfull_a),   32'(ful));
        chk({tag, ".overflow"},  32'({overflow_b, overflow_a}),   32'({ovf, ovf}));
        chk({tag, ".underflow"}, 32'({underflow_b, underflow_a}), 32'({unf, unf}));
        chk({tag, ".flags_f"},
            32'({rempty_b, wfull_b, walmostfull_b, ralmostempty_b}),
            32'({rempty_a, wfull_a, walmostfull_a, ralmostempty_a}));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] fill [4];
        fill[0] = 12'hA; fill[1] = 12'hB; fill[2] = 12'hC; fill[3] = 12'hD;

        rst = 1'b1; flush = 1'b0; w = 1'b0; r = 1'b0; errclr = 1'b0; wd = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk_state("reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset.walmostfull",  32'(walmostfull_a),  32'd0);
        chk("reset.ralmostempty", 32'(ralmostempty_a), 32'd1);
        chk("reset.rd",           32'(rd_a),           32'd0);
        rst = 1'b0;
        tick();
        chk_state("idle", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Fill A..D, then a rejected 5th write
        for (int i = 0; i < 4; i++) begin
            push(fill[i]);
            chk("fill.level",        32'(level_a),        32'(i + 1));
            chk("fill.walmostfull",  32'(walmostfull_a),  32'(i + 1 >= 3));
            chk("fill.ralmostempty", 32'(ralmostempty_a), 32'(i + 1 <= 1));
            chk("fill.wfull",        32'(wfull_a),        32'(i == 3));
        end
        push(12'hE);
        chk_state("overfill", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("drain.fwft_rd", 32'(rd_b), 32'(fill[i]));
            pop();
            chk("drain.reg_rd",  32'(rd_a), 32'(fill[i]));
        end
        chk_state("drained", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        errclr = 1'b1; tick(); errclr = 1'b0;
        chk("errclr.overflow", 32'(overflow_a), 32'd0);

        // Single word: FWFT shows it after the write edge; registered after pop
        push(12'h123);
        chk("single.fwft_rd",     32'(rd_b),   32'h123);
        chk("single.reg_rd_hold", 32'(rd_a),   32'hD);
        chk("single.rempty",      32'(rempty_a), 32'd0);
        pop();
        chk("single.reg_rd",      32'(rd_a),   32'h123);
        chk_state("single.after", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Simultaneous read/write at level 2 for 20 cycles
        push(12'd100);
        push(12'd101);
        for (int i = 0; i < 20; i++) begin
            chk("rw2.fwft_rd", 32'(rd_b), 32'(100 + i));
            r = 1'b1; w = 1'b1; wd = 12'(102 + i);
            tick();
            chk("rw2.level",  32'(level_a), 32'd2);
            chk("rw2.reg_rd", 32'(rd_a),    32'(100 + i));
        end
        r = 1'b0; w = 1'b0;
        pop(); chk("rw2.tail0", 32'(rd_a), 32'd120);
        pop(); chk("rw2.tail1", 32'(rd_a), 32'd121);

        // Simultaneous at empty: write accepted, read rejected
        r = 1'b1; w = 1'b1; wd = 12'h55;
        tick();
        r = 1'b0; w = 1'b0;
        chk_state("rw0", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rw0.reg_rd_hold", 32'(rd_a), 32'd121);
        chk("rw0.fwft_rd",     32'(rd_b), 32'h55);
        errclr = 1'b1; tick(); errclr = 1'b0;
        chk("rw0.errclr", 32'(underflow_a), 32'd0);

        // Simultaneous at full: read accepted, write rejected
        push(12'h56); push(12'h57); push(12'h58);
        chk("rw4.pre_full", 32'(wfull_a), 32'd1);
        r = 1'b1; w = 1'b1; wd = 12'h59;
        tick();
        r = 1'b0; w = 1'b0;
        chk_state("rw4", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rw4.reg_rd", 32'(rd_a), 32'h55);
        pop(); chk("rw4.d0", 32'(rd_a), 32'h56);
        pop(); chk("rw4.d1", 32'(rd_a), 32'h57);
        pop(); chk("rw4.d2", 32'(rd_a), 32'h58);
        errclr = 1'b1; tick(); errclr = 1'b0;

        // Wrap-around: 37 interleaved write/read pairs
        for (int i = 0; i < 37; i++) begin
            push(12'(i));
            chk("wrap.fwft_rd", 32'(rd_b), 32'(i));
            pop();
            chk("wrap.reg_rd",  32'(rd_a), 32'(i));
        end
        chk_state("wrap.end", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Flush at level 3 with a concurrent write; sticky flags untouched
        pop();
        chk("flush.pre_unf", 32'(underflow_a), 32'd1);
        push(12'h1); push(12'h2); push(12'h3);
        flush = 1'b1; w = 1'b1; wd = 12'h7FF;
        tick();
        flush = 1'b0; w = 1'b0;
        chk_state("flush", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("flush.reg_rd_hold", 32'(rd_a), 32'd36);
        tick();
        chk("flush.idle_level", 32'(level_a), 32'd0);
        errclr = 1'b1; tick(); errclr = 1'b0;
        chk("flush.errclr", 32'(underflow_a), 32'd0);

        // Overflow set in the same cycle as errclr wins
        push(12'h201); push(12'h202); push(12'h203); push(12'h204);
        w = 1'b1; errclr = 1'b1; wd = 12'h205;
        tick();
        w = 1'b0;
        chk("race.overflow", 32'(overflow_a), 32'd1);
        tick();
        errclr = 1'b0;
        chk("race.cleared", 32'(overflow_a), 32'd0);

        // Asynchronous reset mid-burst
        pop();
        chk("burst.reg_rd", 32'(rd_a), 32'h201);
        w = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wd = 12'(12'h300 + k);
            tick();
        end
        chk_state("burst", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk_state("arst", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("arst.walmostfull",  32'(walmostfull_a),  32'd0);
        chk("arst.ralmostempty", 32'(ralmostempty_a), 32'd1);
        chk("arst.rd",           32'(rd_a),           32'd0);
        w = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk_state("post_rst", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, parametrised successor to the team's async FIFO, for buffering between blocks that share one clock domain. It adds a selectable read mode (registered or first-word-fall-through), an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. Storage is a Depth x Width register/distributed-RAM array with binary pointers. No Gray coding is needed in a single clock domain.

Parameters:
Width, 12, data word width in bits (>=1)
Depth, 4, number of entries; power of 2, >=2
AlmostFull, 3, walmostfull asserts when level >= AlmostFull; legal range 1..Depth
AlmostEmpty, 1, ralmostempty asserts when level <= AlmostEmpty; legal range 0..Depth-1
FWFT, 0, 0 = registered read (data the cycle after r); 1 = first-word-fall-through

Ports:
clk  input  1  the block's single clock; all state changes on posedge clk
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear of contents
w  input  1  write request
wd  input  Width  write data
wfull  output  1  level == Depth
walmostfull  output  1  level >= AlmostFull
r  input  1  read request (pop)
rd  output  Width  read data
rempty  output  1  level == 0
ralmostempty  output  1  level <= AlmostEmpty
level  output  $clog2(Depth)+1  current occupancy, 0..Depth
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty
errclr  input  1  clears overflow/underflow

Behaviour:
- Reset (rst high, asynchronous):
  - rptr = wptr = 0; level = 0; rempty = 1; wfull = 0; walmostfull = 0; ralmostempty = 1.
  - overflow = underflow = 0; registered rd = 0.
  - Memory contents are not reset. rd in FWFT mode is don't-care while empty.
- Acceptance: a write is accepted iff w & !wfull & !flush. A read is accepted iff r & !rempty & !flush. Both are evaluated against flag values from before the edge.
- Accepted write: mem[wptr] <= wd; wptr wraps modulo Depth.
- Accepted read: rptr wraps modulo Depth.
- Level update:
  - +1 on a write alone; -1 on a read alone.
  - Unchanged on a simultaneous write and read. This is legal at any level in 1..Depth-1.
- Empty with r and w both high: the read is rejected and underflow is set; the write is accepted; level becomes 1.
- Full with r and w both high: the write is rejected and overflow is set; the read is accepted; level becomes Depth-1.
- Flags are decoded from the registered level. They are valid at the same edge the level changes, i.e. zero extra latency. After a write into an empty FIFO, rempty is 0 after that edge.
- FWFT=0 read path:
  - On an accepted read, rd <= mem[rptr] at that edge. The data is valid the cycle after r was sampled.
  - rd holds its value otherwise, including across flush.
- FWFT=1 read path:
  - rd = mem[rptr] combinationally. It is valid whenever rempty = 0.
  - An accepted r pops the current word; rd then shows the next word, or don't-care if now empty.
  - A word written into an empty FIFO appears on rd the cycle after the write edge.
- Flush (synchronous) has the highest priority below rst:
  - rptr = wptr = level = 0; r and w are ignored that cycle.
  - overflow and underflow are unchanged.
  - No error flags are set by requests presented during a flush cycle.
- Sticky errors:
  - overflow <= 1 on w & wfull & !flush.
  - underflow <= 1 on r & rempty & !flush.
  - errclr clears both; a set in the same cycle as errclr wins.
- Threshold arithmetic: compare level unsigned at full level width. An illegal parameter value is an elaboration-time error ($error in an initial or generate check).
- Rejected operations modify neither the pointers nor memory.

Test Plan:
- Reset then idle, Depth=4: rempty=1, ralmostempty=1, wfull=0, walmostfull=0, level=0, overflow=0, underflow=0.
- Fill with 0xA, 0xB, 0xC, 0xD, then a 5th write of 0xE:
  - level sequence 1, 2, 3, 4; walmostfull asserts at level 3; wfull asserts at level 4.
  - The 5th write sets overflow=1 and is dropped.
  - Draining yields A, B, C, D; underflow stays 0.
- FWFT=0 vs FWFT=1, single write 0x123 into an empty FIFO:
  - FWFT=1: rd=0x123 the cycle after the write.
  - FWFT=0: rd=0x123 the cycle after r is sampled.
  - Both modes: rempty=1 after the pop.
- Simultaneous r & w:
  - At level 2 for 20 cycles: level stays 2 and data order is preserved.
  - At level 0: level becomes 1 and underflow=1.
  - At level 4: level becomes 3 and overflow=1.
- Wrap-around: 37 writes interleaved with reads (incrementing data 0..36), with pointers wrapping more than 8 times. The read sequence equals 0..36 exactly.
- Flush, errclr and rst:
  - flush at level 3 with w=1 in the same cycle: level=0, rempty=1, the write is discarded, and the sticky flags are unchanged.
  - errclr clears overflow.
  - rst asserted mid-burst, between clock edges: all outputs take their reset values immediately, without waiting for a clock edge.
